// File: rtl/alu_iq_pkg.sv
// rtl/alu_iq_pkg.sv - shared types and constants for the ALU issue queue
package alu_iq_pkg;

  localparam int IQ_WIDTH     = 32;
  localparam int IQ_ROB_W     = 3;
  localparam int IQ_CTRL_W    = 4;
  localparam int IQ_MAX_DEPTH = 32;

  localparam logic [IQ_CTRL_W-1:0] BUBBLE = '1;

  typedef struct packed {
    logic                valid;
    logic                rdy1;
    logic                rdy2;
    logic [IQ_ROB_W-1:0] tag1;
    logic [IQ_ROB_W-1:0] tag2;
    logic [IQ_WIDTH-1:0] val1;
    logic [IQ_WIDTH-1:0] val2;
    logic [IQ_ROB_W-1:0] rob;
    logic [IQ_CTRL_W-1:0] ctrl;
  } iq_entry_t;

  // Isolates the lowest set bit; callers zero-extend narrower vectors.
  function automatic logic [IQ_MAX_DEPTH-1:0] lowest_one_hot(input logic [IQ_MAX_DEPTH-1:0] v);
    return v & (~v + 1'b1);
  endfunction

endpackage

// File: rtl/alu_iq_age_matrix.sv
// rtl/alu_iq_age_matrix.sv - age matrix picking the oldest requesting entry
module alu_iq_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] oldest_o
);

  // age_q[i][j] = entry i is older than entry j
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [DEPTH-1:0] blocked;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (free_i[i] || free_i[j]) age_d[i][j] = 1'b0;
        if (alloc_i[j] && (i != j)) age_d[i][j] = 1'b1;
        if (alloc_i[i]) age_d[i][j] = 1'b0;
      end
    end
  end

  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (req_i[j] && age_q[j][i]) blocked[i] = 1'b1;
      end
    end
    oldest_o = req_i & ~blocked;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - age-ordered ALU issue queue with CDB wakeup and registered issue stage
module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int WIDTH     = IQ_WIDTH,
  parameter int ROB_W     = IQ_ROB_W,
  parameter int CTRL_W    = IQ_CTRL_W,
  parameter int DEPTH     = 8,
  parameter int CDB_PORTS = 2,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               globalResetN,
  input  logic                               flush,
  input  logic                               dispValid,
  output logic                               dispReady,
  input  logic                               ready1,
  input  logic                               ready2,
  input  logic signed [WIDTH-1:0]            value1,
  input  logic signed [WIDTH-1:0]            value2,
  input  logic [ROB_W-1:0]                   rob1,
  input  logic [ROB_W-1:0]                   rob2,
  input  logic [ROB_W-1:0]                   robInstr,
  input  logic [CTRL_W-1:0]                  aluControl,
  input  logic [CDB_PORTS-1:0]               cdbValid,
  input  logic [CDB_PORTS-1:0][ROB_W-1:0]    cdbTag,
  input  logic [CDB_PORTS-1:0][WIDTH-1:0]    cdbValue,
  input  logic                               execute,
  output logic                               issueValid,
  output logic [ROB_W-1:0]                   instrRob,
  output logic [CTRL_W-1:0]                  instrInfo,
  output logic signed [WIDTH-1:0]            src1,
  output logic signed [WIDTH-1:0]            src2,
  output logic [CNT_W-1:0]                   count,
  output logic                               full
);

  iq_entry_t        entries_q [DEPTH];
  iq_entry_t        entries_d [DEPTH];
  iq_entry_t        disp_entry;
  logic [DEPTH-1:0] valid_vec, req_vec, alloc_oh, alloc_fire_oh, free_oh, age_free, oldest_oh;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             disp_fire, issue_fire;

  logic              iss_valid_q, iss_valid_d;
  logic [ROB_W-1:0]  iss_rob_q, iss_rob_d, sel_rob;
  logic [CTRL_W-1:0] iss_ctrl_q, iss_ctrl_d, sel_ctrl;
  logic [WIDTH-1:0]  iss_src1_q, iss_src1_d, sel_val1;
  logic [WIDTH-1:0]  iss_src2_q, iss_src2_d, sel_val2;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      req_vec[i]   = entries_q[i].valid & entries_q[i].rdy1 & entries_q[i].rdy2;
    end
  end

  assign alloc_oh      = DEPTH'(lowest_one_hot(IQ_MAX_DEPTH'(~valid_vec)));
  assign disp_fire     = dispValid & ~full_q & ~flush;
  assign issue_fire    = execute & (|req_vec) & ~flush;
  assign alloc_fire_oh = disp_fire ? alloc_oh : '0;
  assign free_oh       = issue_fire ? oldest_oh : '0;
  assign age_free      = flush ? '1 : free_oh;

  alu_iq_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk      (clk),
    .rst_n    (globalResetN),
    .alloc_i  (alloc_fire_oh),
    .free_i   (age_free),
    .req_i    (req_vec),
    .oldest_o (oldest_oh)
  );

  always_comb begin
    sel_rob  = '0;
    sel_ctrl = '0;
    sel_val1 = '0;
    sel_val2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oldest_oh[i]) begin
        sel_rob  = entries_q[i].rob;
        sel_ctrl = entries_q[i].ctrl;
        sel_val1 = entries_q[i].val1;
        sel_val2 = entries_q[i].val2;
      end
    end
  end

  // Descending port loops let the lowest matching port win.
  always_comb begin
    disp_entry = '{valid: 1'b1, rdy1: ready1, rdy2: ready2, tag1: rob1, tag2: rob2,
                   val1: value1, val2: value2, rob: robInstr, ctrl: aluControl};
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (!ready1 && cdbValid[p] && cdbTag[p] == rob1) begin
        disp_entry.rdy1 = 1'b1;
        disp_entry.val1 = cdbValue[p];
      end
      if (!ready2 && cdbValid[p] && cdbTag[p] == rob2) begin
        disp_entry.rdy2 = 1'b1;
        disp_entry.val2 = cdbValue[p];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (entries_q[i].valid && !entries_q[i].rdy1 && cdbValid[p] && cdbTag[p] == entries_q[i].tag1) begin
          entries_d[i].rdy1 = 1'b1;
          entries_d[i].val1 = cdbValue[p];
        end
        if (entries_q[i].valid && !entries_q[i].rdy2 && cdbValid[p] && cdbTag[p] == entries_q[i].tag2) begin
          entries_d[i].rdy2 = 1'b1;
          entries_d[i].val2 = cdbValue[p];
        end
      end
      if (free_oh[i]) entries_d[i].valid = 1'b0;
      if (alloc_fire_oh[i]) entries_d[i] = disp_entry;
      if (flush) entries_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    count_d = flush ? '0 : count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_rob_d   = iss_rob_q;
    iss_ctrl_d  = iss_ctrl_q;
    iss_src1_d  = iss_src1_q;
    iss_src2_d  = iss_src2_q;
    if (flush || execute) begin
      iss_valid_d = issue_fire;
      iss_rob_d   = issue_fire ? sel_rob  : '0;
      iss_ctrl_d  = issue_fire ? sel_ctrl : BUBBLE;
      iss_src1_d  = issue_fire ? sel_val1 : '0;
      iss_src2_d  = issue_fire ? sel_val2 : '0;
    end
  end

  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_rob_q   <= '0;
      iss_ctrl_q  <= BUBBLE;
      iss_src1_q  <= '0;
      iss_src2_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      count_q     <= count_d;
      full_q      <= full_d;
      iss_valid_q <= iss_valid_d;
      iss_rob_q   <= iss_rob_d;
      iss_ctrl_q  <= iss_ctrl_d;
      iss_src1_q  <= iss_src1_d;
      iss_src2_q  <= iss_src2_d;
    end
  end

  assign dispReady  = ~full_q;
  assign full       = full_q;
  assign count      = count_q;
  assign issueValid = iss_valid_q;
  assign instrRob   = iss_rob_q;
  assign instrInfo  = iss_ctrl_q;
  assign src1       = iss_src1_q;
  assign src2       = iss_src2_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - scoreboard bench for alu_issue_queue
module tb_alu_issue_queue;

  logic              clk = 1'b0;
  logic              globalResetN, flush, dispValid, dispReady;
  logic              ready1, ready2;
  logic [31:0]       value1, value2;
  logic [2:0]        rob1, rob2, robInstr;
  logic [3:0]        aluControl;
  logic [1:0]        cdbValid;
  logic [1:0][2:0]   cdbTag;
  logic [1:0][31:0]  cdbValue;
  logic              execute, issueValid, full;
  logic [2:0]        instrRob;
  logic [3:0]        instrInfo;
  logic [31:0]       src1, src2;
  logic [3:0]        count;

  typedef struct {
    logic [2:0]  rob;
    logic [3:0]  ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exec_seen = 1'b0;

  alu_issue_queue dut (
    .clk(clk), .globalResetN(globalResetN), .flush(flush),
    .dispValid(dispValid), .dispReady(dispReady),
    .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2),
    .rob1(rob1), .rob2(rob2), .robInstr(robInstr), .aluControl(aluControl),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbValue(cdbValue),
    .execute(execute), .issueValid(issueValid), .instrRob(instrRob),
    .instrInfo(instrInfo), .src1(src1), .src2(src2), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_disp(input logic r1, input logic [31:0] v1, input logic [2:0] t1,
                          input logic r2, input logic [31:0] v2, input logic [2:0] t2,
                          input logic [2:0] rob, input logic [3:0] ctrl);
    dispValid = 1'b1; ready1 = r1; value1 = v1; rob1 = t1;
    ready2 = r2; value2 = v2; rob2 = t2; robInstr = rob; aluControl = ctrl;
  endtask

  task automatic push_exp(input logic [2:0] rob, input logic [3:0] ctrl,
                          input logic [31:0] s1, input logic [31:0] s2);
    exp_t x;
    x.rob = rob; x.ctrl = ctrl; x.s1 = s1; x.s2 = s2;
    sb.push_back(x);
  endtask

  // An issue-stage load happens only at edges where execute was high and flush low.
  always @(posedge clk) exec_seen <= execute & ~flush & globalResetN;

  always @(negedge clk) begin
    if (exec_seen && globalResetN) begin
      if (issueValid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_issue: got rob %0d, expected no issue", instrRob);
        end else begin
          e = sb.pop_front();
          chk("issue_rob",  32'(instrRob),  32'(e.rob));
          chk("issue_ctrl", 32'(instrInfo), 32'(e.ctrl));
          chk("issue_src1", src1, e.s1);
          chk("issue_src2", src2, e.s2);
        end
      end else begin
        chk("bubble_info", 32'(instrInfo), 32'hF);
      end
    end
  end

  initial begin
    globalResetN = 1'b0; flush = 1'b0; dispValid = 1'b0; execute = 1'b0;
    ready1 = 1'b0; ready2 = 1'b0; value1 = '0; value2 = '0;
    rob1 = '0; rob2 = '0; robInstr = '0; aluControl = '0;
    cdbValid = '0; cdbTag = '0; cdbValue = '0;
    tick(); tick();
    globalResetN = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dispReady", 32'(dispReady), 32'd1);
    chk("rst_info", 32'(instrInfo), 32'hF);

    // Reset mid-traffic
    set_disp(1, 32'd1, 3'd0, 1, 32'd2, 3'd0, 3'd1, 4'h2); tick();
    set_disp(1, 32'd3, 3'd0, 1, 32'd4, 3'd0, 3'd2, 4'h2); tick();
    dispValid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd2);
    #2 globalResetN = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_dispReady", 32'(dispReady), 32'd1);
    chk("arst_issueValid", 32'(issueValid), 32'd0);
    chk("arst_info", 32'(instrInfo), 32'hF);
    chk("arst_rob", 32'(instrRob), 32'd0);
    chk("arst_src1", src1, 32'd0);
    chk("arst_src2", src2, 32'd0);
    @(negedge clk);
    globalResetN = 1'b1;
    execute = 1'b1;
    tick();

    // Ready ADD: visible two edges after dispatch
    set_disp(1, 32'd5, 3'd0, 1, 32'd7, 3'd0, 3'd3, 4'h0);
    push_exp(3'd3, 4'h0, 32'd5, 32'd7);
    tick();
    dispValid = 1'b0;
    chk("add_not_yet", 32'(issueValid), 32'd0);
    tick();
    chk("add_issued", 32'(issueValid), 32'd1);
    tick(); tick();

    // A waits on tag 3, B ready; wakeup on port 1 lets B go first
    set_disp(0, 32'd0, 3'd3, 1, 32'd4, 3'd0, 3'd2, 4'h1); tick();
    set_disp(1, 32'd11, 3'd0, 1, 32'd22, 3'd0, 3'd4, 4'h1); tick();
    dispValid = 1'b0;
    push_exp(3'd4, 4'h1, 32'd11, 32'd22);
    push_exp(3'd2, 4'h1, 32'h10, 32'd4);
    cdbValid = 2'b10; cdbTag[1] = 3'd3; cdbValue[1] = 32'h10; cdbTag[0] = 3'd3; cdbValue[0] = 32'h99;
    tick();
    cdbValid = '0;
    tick(); tick(); tick();

    // Dispatch-cycle bypass of tag 6 = -2
    set_disp(1, 32'd9, 3'd0, 0, 32'd0, 3'd6, 3'd5, 4'h4);
    cdbValid = 2'b01; cdbTag[0] = 3'd6; cdbValue[0] = 32'hFFFF_FFFE;
    push_exp(3'd5, 4'h4, 32'd9, 32'hFFFF_FFFE);
    tick();
    dispValid = 1'b0; cdbValid = '0;
    tick();
    chk("bypass_issued", 32'(issueValid), 32'd1);
    tick(); tick();

    // Both ports match tag 2: port 0 value wins
    set_disp(1, 32'd1, 3'd0, 0, 32'd0, 3'd2, 3'd5, 4'h6); tick();
    dispValid = 1'b0;
    push_exp(3'd5, 4'h6, 32'd1, 32'h20);
    cdbValid = 2'b11; cdbTag[0] = 3'd2; cdbValue[0] = 32'h20; cdbTag[1] = 3'd2; cdbValue[1] = 32'h30;
    tick();
    cdbValid = '0;
    tick(); tick(); tick();

    // Fill all eight entries waiting on tag 1
    for (int i = 0; i < 8; i++) begin
      set_disp(0, 32'd0, 3'd1, 1, 32'(100 + i), 3'd0, 3'(i), 4'h3);
      push_exp(3'(i), 4'h3, 32'h100, 32'(100 + i));
      tick();
    end
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_dispReady", 32'(dispReady), 32'd0);
    set_disp(1, 32'hDEAD, 3'd0, 1, 32'hBEEF, 3'd0, 3'd7, 4'h7); tick();
    dispValid = 1'b0;
    chk("ninth_dropped", 32'(count), 32'd8);
    cdbValid = 2'b01; cdbTag[0] = 3'd1; cdbValue[0] = 32'h100;
    tick();
    cdbValid = '0;
    chk("wake_count", 32'(count), 32'd8);
    for (int k = 7; k >= 0; k--) begin
      tick();
      chk("drain_count", 32'(count), 32'(k));
    end
    tick(); tick();

    // Hold with execute low, then flush
    set_disp(0, 32'd0, 3'd4, 1, 32'd1, 3'd0, 3'd6, 4'h5); tick();
    set_disp(1, 32'h55, 3'd0, 1, 32'h66, 3'd0, 3'd1, 4'h5);
    push_exp(3'd1, 4'h5, 32'h55, 32'h66);
    tick();
    set_disp(1, 32'h77, 3'd0, 1, 32'h88, 3'd0, 3'd2, 4'h5); tick();
    dispValid = 1'b0;
    execute = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_valid", 32'(issueValid), 32'd1);
      chk("hold_rob", 32'(instrRob), 32'd1);
      chk("hold_src1", src1, 32'h55);
      chk("hold_count", 32'(count), 32'd2);
    end
    flush = 1'b1; execute = 1'b1;
    set_disp(1, 32'd1, 3'd0, 1, 32'd1, 3'd0, 3'd3, 4'h8);
    tick();
    flush = 1'b0; dispValid = 1'b0;
    chk("flush_valid", 32'(issueValid), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_info", 32'(instrInfo), 32'hF);
    chk("flush_dispReady", 32'(dispReady), 32'd1);
    cdbValid = 2'b01; cdbTag[0] = 3'd4; cdbValue[0] = 32'h44;
    tick();
    cdbValid = '0;
    tick(); tick(); tick();
    chk("no_revive_count", 32'(count), 32'd0);
    chk("no_revive_valid", 32'(issueValid), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
